id_ex_issue: RTL
================

Name: id_ex_issue

Overview:
- Decode-to-execute issue stage: decodes a 32-bit MIPS instruction, selects operands and registers the ALU control bundle into the ID/EX pipeline register.
- Produces exactly what the ALU consumes (a, b, 8-bit op, sa) plus writeback/memory control for later stages.
- Sits between register-file read and the ALU, with valid/ready handshakes on both sides and a synchronous flush for branch/exception squash.

Parameters:
- DATA_W, 32, operand/instruction width.
- OP_W, 8, ALU op code width (EXE_*_OP encodings from the shared defines).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  squash register contents next edge.
- in_valid  in  1  upstream holds a decodable instruction.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction PC.
- in_rs_data  in  32  GPR[rs].
- in_rt_data  in  32  GPR[rt].
- out_valid  out  1  registered bundle valid.
- out_ready  in  1  execute stage accepts.
- out_a, out_b  out  32  ALU operands.
- out_op  out  8  ALU op (EXE_*_OP).
- out_sa  out  5  shift amount.
- out_wr_en, out_wr_addr  out  1/5  GPR writeback.
- out_mem_rd, out_mem_wr  out  1/1  LW/SW.
- out_store_data  out  32  rt data for SW.
- out_is_branch  out  1  BEQ.
- out_illegal  out  1  unrecognised encoding.
- out_pc  out  32  registered PC.

Behaviour:
- Reset (rst_n low, async): every output register 0, including out_valid=0 and out_op=EXE_NOP_OP (8'h00). in_ready is combinational and equals 1 while reset is deasserted and the register is empty. Reset asserted mid-transfer drops the bundle.
- Handshake: in_ready = !out_valid | out_ready. Load when in_valid & in_ready, with 1-cycle latency to out_valid. When out_valid & !out_ready, all out_* hold stable.
- Flush: on the next edge out_valid=0 and no load occurs, even if in_valid & in_ready. Flush has priority over load. Registered data other than out_valid may be left stale.
- R-type (opcode 000000), decoded by funct:
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR
  - 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU
  - 101010 SLT, 101011 SLTU
  - 000000 SLL, 000010 SRL, 000011 SRA
  - 000100 SLLV, 000110 SRLV, 000111 SRAV
  - Operands: a=rs_data, b=rt_data, sa=instr[10:6], wr_addr=rd.
- I-type: a=rs_data, wr_addr=rt.
  - Zero-extended imm: 001100 ANDI, 001101 ORI, 001110 XORI.
  - LUI (001111): b = zero-extended imm. The ALU places b[15:0] in the high half.
  - Sign-extended imm: 001000 ADDI, 001001 ADDIU, 001010 SLTI, 001011 SLTIU (the SLTIU compare is unsigned on the sign-extended value).
  - LW (100011): b = sign-extended imm, mem_rd=1, wr_en=1.
  - SW (101011): b = sign-extended imm, mem_wr=1, store_data=rt_data, wr_en=0.
  - BEQ (000100): b=rt_data, op=EXE_BEQ_OP, is_branch=1, wr_en=0.
  - sa=0 for all I-type.
- wr_en is forced to 0 when wr_addr==0.
- Any other opcode/funct combination: op=EXE_NOP_OP, a=b=0, wr_en=mem_rd=mem_wr=0, illegal=1. The bundle is still issued with out_valid=1; exception handling is done downstream.
- Instruction word 0 (SLL r0,r0,0) is a legal NOP: op=EXE_SLL_OP, wr_en=0.

Decomposition:
- Shared defines: EXE_*_OP codes, EXE_NOP_OP, opcode/funct constants (OPC_RTYPE, FN_ADD, ...).
- Sub-module inst_decode: purely combinational instruction-to-control bundle. The top level holds the handshake and pipeline register.

Test Plan:
- in_instr=0x012A4020 (add t0,t1,t2), rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, op=EXE_ADD_OP, a=5, b=7, wr_addr=8, wr_en=1.
- ori 0x3508FFFF, rs=0x12340000 -> b=0x0000FFFF, op=EXE_ORI_OP. Then addi 0x2108FFFF -> b=0xFFFFFFFF, op=EXE_ADDI_OP.
- sll 0x00084100 (sa=4) -> op=EXE_SLL_OP, sa=4, wr_addr=8. Then sw 0xAD090004, rt=0xCAFE -> mem_wr=1, b=4, store_data=0xCAFE, wr_en=0.
- out_ready=0 for 3 cycles with a second instruction pending -> in_ready=0 and outputs constant. Release -> second bundle appears one cycle later, with none lost or duplicated.
- flush together with in_valid=1 and in_ready=1 -> out_valid=0 next cycle. rst_n pulsed low mid-stall -> out_valid=0 immediately (async) and out_op=0.
- opcode 111111 -> out_illegal=1, op=EXE_NOP_OP, wr_en=0. addu with rd=0 -> wr_en=0.

Source files
------------

// File: rtl/id_ex_issue_pkg.sv
// Shared decode constants and the ID/EX control bundle for the id_ex_issue stage.
// EXE_*_OP values are the ALU op encodings; EXE_NOP_OP must stay 8'h00 (reset value).
package id_ex_issue_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned OPW  = 8;

   localparam logic [7:0] EXE_NOP_OP   = 8'h00;
   localparam logic [7:0] EXE_AND_OP   = 8'h24;
   localparam logic [7:0] EXE_OR_OP    = 8'h25;
   localparam logic [7:0] EXE_XOR_OP   = 8'h26;
   localparam logic [7:0] EXE_NOR_OP   = 8'h27;
   localparam logic [7:0] EXE_ADD_OP   = 8'h20;
   localparam logic [7:0] EXE_ADDU_OP  = 8'h21;
   localparam logic [7:0] EXE_SUB_OP   = 8'h22;
   localparam logic [7:0] EXE_SUBU_OP  = 8'h23;
   localparam logic [7:0] EXE_SLT_OP   = 8'h2A;
   localparam logic [7:0] EXE_SLTU_OP  = 8'h2B;
   localparam logic [7:0] EXE_SLL_OP   = 8'h7C;
   localparam logic [7:0] EXE_SRL_OP   = 8'h02;
   localparam logic [7:0] EXE_SRA_OP   = 8'h03;
   localparam logic [7:0] EXE_SLLV_OP  = 8'h04;
   localparam logic [7:0] EXE_SRLV_OP  = 8'h06;
   localparam logic [7:0] EXE_SRAV_OP  = 8'h07;
   localparam logic [7:0] EXE_ANDI_OP  = 8'h59;
   localparam logic [7:0] EXE_ORI_OP   = 8'h5A;
   localparam logic [7:0] EXE_XORI_OP  = 8'h5B;
   localparam logic [7:0] EXE_LUI_OP   = 8'h5C;
   localparam logic [7:0] EXE_ADDI_OP  = 8'h55;
   localparam logic [7:0] EXE_ADDIU_OP = 8'h56;
   localparam logic [7:0] EXE_SLTI_OP  = 8'h57;
   localparam logic [7:0] EXE_SLTIU_OP = 8'h58;
   localparam logic [7:0] EXE_LW_OP    = 8'hE3;
   localparam logic [7:0] EXE_SW_OP    = 8'hEB;
   localparam logic [7:0] EXE_BEQ_OP   = 8'h51;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;
   localparam logic [5:0] OPC_ADDIU = 6'b001001;
   localparam logic [5:0] OPC_SLTI  = 6'b001010;
   localparam logic [5:0] OPC_SLTIU = 6'b001011;
   localparam logic [5:0] OPC_ANDI  = 6'b001100;
   localparam logic [5:0] OPC_ORI   = 6'b001101;
   localparam logic [5:0] OPC_XORI  = 6'b001110;
   localparam logic [5:0] OPC_LUI   = 6'b001111;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_SLLV = 6'b000100;
   localparam logic [5:0] FN_SRLV = 6'b000110;
   localparam logic [5:0] FN_SRAV = 6'b000111;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [OPW-1:0]  op;
      logic [4:0]      sa;
      logic            wr_en;
      logic [4:0]      wr_addr;
      logic            mem_rd;
      logic            mem_wr;
      logic [XLEN-1:0] store_data;
      logic            is_branch;
      logic            illegal;
   } issue_t;

endpackage

// File: rtl/id_ex_issue_inst_decode.sv
// Purely combinational MIPS instruction decode into the ALU/writeback/memory control bundle.
module id_ex_issue_inst_decode
   import id_ex_issue_pkg::*;
(
   input  logic [31:0] i_instr,
   input  logic [31:0] i_rs_data,
   input  logic [31:0] i_rt_data,
   output logic [31:0] o_a,
   output logic [31:0] o_b,
   output logic [7:0]  o_op,
   output logic [4:0]  o_sa,
   output logic        o_wr_en,
   output logic [4:0]  o_wr_addr,
   output logic        o_mem_rd,
   output logic        o_mem_wr,
   output logic [31:0] o_store_data,
   output logic        o_is_branch,
   output logic        o_illegal
);

   logic [5:0]  w_opc;
   logic [5:0]  w_fn;
   logic [31:0] w_zext;
   logic [31:0] w_sext;
   logic        w_legal;
   logic        w_unused_rs;
   issue_t      w_dec;

   assign w_opc  = i_instr[31:26];
   assign w_fn   = i_instr[5:0];
   assign w_zext = {16'h0000, i_instr[15:0]};
   assign w_sext = {{16{i_instr[15]}}, i_instr[15:0]};
   // rs index is resolved by the register file upstream; only its data arrives here.
   assign w_unused_rs = ^i_instr[25:21];

   always_comb begin
      w_dec    = '0;
      w_dec.op = EXE_NOP_OP;
      w_legal  = 1'b1;
      if (w_opc == OPC_RTYPE) begin
         w_dec.a       = i_rs_data;
         w_dec.b       = i_rt_data;
         w_dec.sa      = i_instr[10:6];
         w_dec.wr_addr = i_instr[15:11];
         w_dec.wr_en   = 1'b1;
         case (w_fn)
            FN_AND:  w_dec.op = EXE_AND_OP;
            FN_OR:   w_dec.op = EXE_OR_OP;
            FN_XOR:  w_dec.op = EXE_XOR_OP;
            FN_NOR:  w_dec.op = EXE_NOR_OP;
            FN_ADD:  w_dec.op = EXE_ADD_OP;
            FN_ADDU: w_dec.op = EXE_ADDU_OP;
            FN_SUB:  w_dec.op = EXE_SUB_OP;
            FN_SUBU: w_dec.op = EXE_SUBU_OP;
            FN_SLT:  w_dec.op = EXE_SLT_OP;
            FN_SLTU: w_dec.op = EXE_SLTU_OP;
            FN_SLL:  w_dec.op = EXE_SLL_OP;
            FN_SRL:  w_dec.op = EXE_SRL_OP;
            FN_SRA:  w_dec.op = EXE_SRA_OP;
            FN_SLLV: w_dec.op = EXE_SLLV_OP;
            FN_SRLV: w_dec.op = EXE_SRLV_OP;
            FN_SRAV: w_dec.op = EXE_SRAV_OP;
            default: w_legal  = 1'b0;
         endcase
      end else begin
         w_dec.a       = i_rs_data;
         w_dec.b       = w_sext;
         w_dec.wr_addr = i_instr[20:16];
         w_dec.wr_en   = 1'b1;
         case (w_opc)
            OPC_ANDI:  begin w_dec.op = EXE_ANDI_OP; w_dec.b = w_zext; end
            OPC_ORI:   begin w_dec.op = EXE_ORI_OP;  w_dec.b = w_zext; end
            OPC_XORI:  begin w_dec.op = EXE_XORI_OP; w_dec.b = w_zext; end
            OPC_LUI:   begin w_dec.op = EXE_LUI_OP;  w_dec.b = w_zext; end
            OPC_ADDI:  w_dec.op = EXE_ADDI_OP;
            OPC_ADDIU: w_dec.op = EXE_ADDIU_OP;
            OPC_SLTI:  w_dec.op = EXE_SLTI_OP;
            OPC_SLTIU: w_dec.op = EXE_SLTIU_OP;
            OPC_LW: begin
               w_dec.op     = EXE_LW_OP;
               w_dec.mem_rd = 1'b1;
            end
            OPC_SW: begin
               w_dec.op         = EXE_SW_OP;
               w_dec.mem_wr     = 1'b1;
               w_dec.store_data = i_rt_data;
               w_dec.wr_en      = 1'b0;
            end
            OPC_BEQ: begin
               w_dec.op        = EXE_BEQ_OP;
               w_dec.b         = i_rt_data;
               w_dec.is_branch = 1'b1;
               w_dec.wr_en     = 1'b0;
            end
            default: w_legal = 1'b0;
         endcase
      end
      if (!w_legal) begin
         w_dec         = '0;
         w_dec.op      = EXE_NOP_OP;
         w_dec.illegal = 1'b1;
      end
      if (w_dec.wr_addr == 5'd0) w_dec.wr_en = 1'b0;
   end

   assign o_a          = w_dec.a;
   assign o_b          = w_dec.b;
   assign o_op         = w_dec.op;
   assign o_sa         = w_dec.sa;
   assign o_wr_en      = w_dec.wr_en;
   assign o_wr_addr    = w_dec.wr_addr;
   assign o_mem_rd     = w_dec.mem_rd;
   assign o_mem_wr     = w_dec.mem_wr;
   assign o_store_data = w_dec.store_data;
   assign o_is_branch  = w_dec.is_branch;
   assign o_illegal    = w_dec.illegal;

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX issue stage: decode plus a single valid/ready pipeline register with synchronous flush.
module id_ex_issue
   import id_ex_issue_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_instr,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_rs_data,
   input  logic [DATA_W-1:0] in_rt_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [OP_W-1:0]   out_op,
   output logic [4:0]        out_sa,
   output logic              out_wr_en,
   output logic [4:0]        out_wr_addr,
   output logic              out_mem_rd,
   output logic              out_mem_wr,
   output logic [DATA_W-1:0] out_store_data,
   output logic              out_is_branch,
   output logic              out_illegal,
   output logic [DATA_W-1:0] out_pc
);

   issue_t            w_dec;
   issue_t            r_bundle;
   logic              r_valid;
   logic [DATA_W-1:0] r_pc;
   logic              w_load;

   id_ex_issue_inst_decode u_decode (
      .i_instr      (in_instr),
      .i_rs_data    (in_rs_data),
      .i_rt_data    (in_rt_data),
      .o_a          (w_dec.a),
      .o_b          (w_dec.b),
      .o_op         (w_dec.op),
      .o_sa         (w_dec.sa),
      .o_wr_en      (w_dec.wr_en),
      .o_wr_addr    (w_dec.wr_addr),
      .o_mem_rd     (w_dec.mem_rd),
      .o_mem_wr     (w_dec.mem_wr),
      .o_store_data (w_dec.store_data),
      .o_is_branch  (w_dec.is_branch),
      .o_illegal    (w_dec.illegal)
   );

   assign in_ready = !r_valid || out_ready;
   assign w_load   = in_valid && in_ready && !flush;

   // Flush only clears valid; payload may stay stale since nothing downstream reads it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid  <= 1'b0;
         r_bundle <= '0;
         r_pc     <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_valid  <= 1'b1;
         r_bundle <= w_dec;
         r_pc     <= in_pc;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid      = r_valid;
   assign out_a          = r_bundle.a;
   assign out_b          = r_bundle.b;
   assign out_op         = r_bundle.op;
   assign out_sa         = r_bundle.sa;
   assign out_wr_en      = r_bundle.wr_en;
   assign out_wr_addr    = r_bundle.wr_addr;
   assign out_mem_rd     = r_bundle.mem_rd;
   assign out_mem_wr     = r_bundle.mem_wr;
   assign out_store_data = r_bundle.store_data;
   assign out_is_branch  = r_bundle.is_branch;
   assign out_illegal    = r_bundle.illegal;
   assign out_pc         = r_pc;

endmodule
